// File: rtl/sd_sdram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_loader_pkg
// Description : Shared constants and enumerations for the SD-to-SDRAM loader:
//               SD slave register map, ASR bit positions, command code,
//               error codes and loader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_loader_pkg;

  // SD Avalon slave word map
  localparam logic [7:0]  c_sd_buf_base  = 8'd0;
  localparam logic [7:0]  c_sd_reg_arg   = 8'd139;
  localparam logic [7:0]  c_sd_reg_cmd   = 8'd140;
  localparam logic [7:0]  c_sd_reg_asr   = 8'd141;

  // Aux status register bit positions
  localparam int          c_asr_card_present = 1;
  localparam int          c_asr_cmd_busy     = 2;
  localparam int          c_asr_cmd_error    = 4;

  // Single-block read command
  localparam logic [31:0] c_sd_cmd_read_block = 32'd17;

  // 32-bit words per 512-byte sector
  localparam logic [6:0]  c_last_word_idx = 7'd127;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_NO_CARD      = 2'd1,
    ERR_POLL_TIMEOUT = 2'd2,
    ERR_SD_CMD       = 2'd3
  } err_code_e;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CHK  = 4'd1,
    S_ARG  = 4'd2,
    S_CMD  = 4'd3,
    S_POLL = 4'd4,
    S_RD   = 4'd5,
    S_WLO  = 4'd6,
    S_WHI  = 4'd7,
    S_DONE = 4'd8,
    S_ERR  = 4'd9
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sd_sdram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_sdram_loader_if
// Description : Bus bundle for the loader: SD card Avalon slave port and
//               SDRAM controller s1 port. The loader is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_sdram_loader_if #(
  parameter int SDRAM_AW = 25
);
  // SD card slave
  logic                sd_chipselect;
  logic                sd_read;
  logic                sd_write;
  logic [7:0]          sd_address;
  logic [3:0]          sd_byteenable;
  logic [31:0]         sd_writedata;
  logic [31:0]         sd_readdata;
  logic                sd_waitrequest;

  // SDRAM s1 slave
  logic [SDRAM_AW-1:0] sdram_address;
  logic [1:0]          sdram_byteenable_n;
  logic                sdram_chipselect;
  logic                sdram_write_n;
  logic                sdram_read_n;
  logic [15:0]         sdram_writedata;
  logic                sdram_waitrequest;

  modport master (
    output sd_chipselect, sd_read, sd_write, sd_address, sd_byteenable, sd_writedata,
    input  sd_readdata, sd_waitrequest,
    output sdram_address, sdram_byteenable_n, sdram_chipselect, sdram_write_n,
           sdram_read_n, sdram_writedata,
    input  sdram_waitrequest
  );

  modport slave (
    input  sd_chipselect, sd_read, sd_write, sd_address, sd_byteenable, sd_writedata,
    output sd_readdata, sd_waitrequest,
    input  sdram_address, sdram_byteenable_n, sdram_chipselect, sdram_write_n,
           sdram_read_n, sdram_writedata,
    output sdram_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/sd_sdram_loader_avm_single_xfer.sv
`default_nettype none
// ============================================================================
// Module      : avm_single_xfer
// Description : Generic single-beat Avalon-MM master. A one-cycle request
//               launches a read or write; address, data and strobe are held
//               until waitrequest is low, then a one-cycle ack is returned
//               together with the read data captured on the completing edge.
// Revision    : 1.0 - initial release
// ============================================================================
module avm_single_xfer #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  // request side
  input  wire logic          i_req,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [DW-1:0] i_wdata,
  output      logic          o_ack,
  output      logic [DW-1:0] o_rdata,
  // Avalon side
  output      logic          o_cs,
  output      logic          o_rd,
  output      logic          o_wr,
  output      logic [AW-1:0] o_addr,
  output      logic [DW-1:0] o_wdata,
  input  wire logic          i_waitrequest,
  input  wire logic [DW-1:0] i_rdata
);

  logic          r_active;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  // Launch on request, hold until the slave drops waitrequest, then ack once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      o_ack    <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_ack <= 1'b0;
      if (r_active) begin
        if (!i_waitrequest) begin
          r_active <= 1'b0;
          o_ack    <= 1'b1;
          if (!r_we) begin
            o_rdata <= i_rdata;
          end
        end
      end else if (i_req) begin
        r_active <= 1'b1;
        r_we     <= i_we;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end
    end
  end

  assign o_cs    = r_active;
  assign o_rd    = r_active & ~r_we;
  assign o_wr    = r_active & r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/sd_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module      : sd_sdram_loader
// Description : Copies a run of 512-byte SD sectors into SDRAM. Sequences
//               card check, argument/command writes, status polling and the
//               128-word buffer drain, splitting each 32-bit word into two
//               16-bit SDRAM writes (low half first).
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sdram_loader
  import sd_loader_pkg::*;
#(
  parameter int          SDRAM_AW        = 25,
  parameter logic [23:0] POLL_LIMIT      = 24'd5_000_000,
  parameter bit          BYTE_ADDRESSING = 1'b1
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                start,
  input  wire logic [31:0]         sector_start,
  input  wire logic [15:0]         sector_count,
  input  wire logic [SDRAM_AW-1:0] sdram_base,
  output      logic                busy,
  output      logic                done,
  output      logic                error,
  output      logic [1:0]          error_code,
  output      logic [15:0]         sectors_done,
  sd_sdram_loader_if.master        bus
);

  state_e              r_state;
  logic                r_issued;
  logic                r_sd_req;
  logic                r_sd_we;
  logic [7:0]          r_sd_addr;
  logic [31:0]         r_sd_wdata;
  logic                r_dr_req;
  logic [SDRAM_AW-1:0] r_dr_addr;
  logic [15:0]         r_dr_wdata;
  logic [31:0]         r_sector;
  logic [15:0]         r_remaining;
  logic [SDRAM_AW-1:0] r_dst;
  logic [6:0]          r_word_idx;
  logic [31:0]         r_word;
  logic [23:0]         r_poll_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  err_code_e           r_err_code;
  logic [15:0]         r_sectors_done;

  logic                w_sd_ack;
  logic [31:0]         w_sd_rdata;
  logic                w_sd_cs;
  logic                w_sd_rd;
  logic                w_sd_wr;
  logic [7:0]          w_sd_addr;
  logic [31:0]         w_sd_wdata;
  logic                w_dr_ack;
  logic [15:0]         w_dr_rdata_unused;
  logic                w_dr_cs;
  logic                w_dr_rd_unused;
  logic                w_dr_wr;
  logic [SDRAM_AW-1:0] w_dr_addr;
  logic [15:0]         w_dr_wdata;
  logic [31:0]         w_arg;

  // SDSC cards take a byte address; the shift deliberately drops the top bits.
  assign w_arg = BYTE_ADDRESSING ? {r_sector[22:0], 9'd0} : r_sector;

  // Loader sequencer: each bus state issues one request, then waits for its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_issued       <= 1'b0;
      r_sd_req       <= 1'b0;
      r_sd_we        <= 1'b0;
      r_sd_addr      <= '0;
      r_sd_wdata     <= '0;
      r_dr_req       <= 1'b0;
      r_dr_addr      <= '0;
      r_dr_wdata     <= '0;
      r_sector       <= '0;
      r_remaining    <= '0;
      r_dst          <= '0;
      r_word_idx     <= '0;
      r_word         <= '0;
      r_poll_cnt     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_sectors_done <= '0;
    end else begin
      r_sd_req <= 1'b0;
      r_dr_req <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_issued <= 1'b0;
          if (start) begin
            r_sector       <= sector_start;
            r_remaining    <= sector_count;
            r_dst          <= sdram_base;
            r_sectors_done <= '0;
            r_err_code     <= ERR_NONE;
            if (sector_count == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (!r_issued) begin
            r_sd_req  <= 1'b1;
            r_sd_we   <= 1'b0;
            r_sd_addr <= c_sd_reg_asr;
            r_issued  <= 1'b1;
          end else if (w_sd_ack) begin
            r_issued <= 1'b0;
            if (!w_sd_rdata[c_asr_card_present]) begin
              r_err_code <= ERR_NO_CARD;
              r_state    <= S_ERR;
            end else begin
              r_state <= S_ARG;
            end
          end
        end
        S_ARG: begin
          if (!r_issued) begin
            r_sd_req   <= 1'b1;
            r_sd_we    <= 1'b1;
            r_sd_addr  <= c_sd_reg_arg;
            r_sd_wdata <= w_arg;
            r_issued   <= 1'b1;
          end else if (w_sd_ack) begin
            r_issued <= 1'b0;
            r_state  <= S_CMD;
          end
        end
        S_CMD: begin
          if (!r_issued) begin
            r_sd_req   <= 1'b1;
            r_sd_we    <= 1'b1;
            r_sd_addr  <= c_sd_reg_cmd;
            r_sd_wdata <= c_sd_cmd_read_block;
            r_issued   <= 1'b1;
          end else if (w_sd_ack) begin
            r_issued   <= 1'b0;
            r_poll_cnt <= '0;
            r_state    <= S_POLL;
          end
        end
        S_POLL: begin
          if (!r_issued) begin
            r_sd_req  <= 1'b1;
            r_sd_we   <= 1'b0;
            r_sd_addr <= c_sd_reg_asr;
            r_issued  <= 1'b1;
          end else if (w_sd_ack) begin
            r_issued <= 1'b0;
            if (w_sd_rdata[c_asr_cmd_busy]) begin
              // Count every busy status read; give up once the budget is spent.
              if (r_poll_cnt + 24'd1 == POLL_LIMIT) begin
                r_err_code <= ERR_POLL_TIMEOUT;
                r_state    <= S_ERR;
              end else begin
                r_poll_cnt <= r_poll_cnt + 24'd1;
              end
            end else if (w_sd_rdata[c_asr_cmd_error]) begin
              r_err_code <= ERR_SD_CMD;
              r_state    <= S_ERR;
            end else begin
              r_word_idx <= '0;
              r_state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!r_issued) begin
            r_sd_req  <= 1'b1;
            r_sd_we   <= 1'b0;
            r_sd_addr <= c_sd_buf_base + {1'b0, r_word_idx};
            r_issued  <= 1'b1;
          end else if (w_sd_ack) begin
            r_issued <= 1'b0;
            r_word   <= w_sd_rdata;
            r_state  <= S_WLO;
          end
        end
        S_WLO: begin
          if (!r_issued) begin
            r_dr_req   <= 1'b1;
            r_dr_addr  <= r_dst;
            r_dr_wdata <= r_word[15:0];
            r_issued   <= 1'b1;
          end else if (w_dr_ack) begin
            r_issued <= 1'b0;
            r_state  <= S_WHI;
          end
        end
        S_WHI: begin
          if (!r_issued) begin
            r_dr_req   <= 1'b1;
            r_dr_addr  <= r_dst + SDRAM_AW'(1);
            r_dr_wdata <= r_word[31:16];
            r_issued   <= 1'b1;
          end else if (w_dr_ack) begin
            r_issued <= 1'b0;
            r_dst    <= r_dst + SDRAM_AW'(2);
            if (r_word_idx != c_last_word_idx) begin
              r_word_idx <= r_word_idx + 7'd1;
              r_state    <= S_RD;
            end else begin
              // Sector complete; the card check is not repeated for the next one.
              r_sectors_done <= r_sectors_done + 16'd1;
              r_sector       <= r_sector + 32'd1;
              r_remaining    <= r_remaining - 16'd1;
              r_state        <= (r_remaining == 16'd1) ? S_DONE : S_ARG;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  avm_single_xfer #(
    .AW (8),
    .DW (32)
  ) u_sd_xfer (
    .clk           (clk),
    .reset         (reset),
    .i_req         (r_sd_req),
    .i_we          (r_sd_we),
    .i_addr        (r_sd_addr),
    .i_wdata       (r_sd_wdata),
    .o_ack         (w_sd_ack),
    .o_rdata       (w_sd_rdata),
    .o_cs          (w_sd_cs),
    .o_rd          (w_sd_rd),
    .o_wr          (w_sd_wr),
    .o_addr        (w_sd_addr),
    .o_wdata       (w_sd_wdata),
    .i_waitrequest (bus.sd_waitrequest),
    .i_rdata       (bus.sd_readdata)
  );

  avm_single_xfer #(
    .AW (SDRAM_AW),
    .DW (16)
  ) u_sdram_xfer (
    .clk           (clk),
    .reset         (reset),
    .i_req         (r_dr_req),
    .i_we          (1'b1),
    .i_addr        (r_dr_addr),
    .i_wdata       (r_dr_wdata),
    .o_ack         (w_dr_ack),
    .o_rdata       (w_dr_rdata_unused),
    .o_cs          (w_dr_cs),
    .o_rd          (w_dr_rd_unused),
    .o_wr          (w_dr_wr),
    .o_addr        (w_dr_addr),
    .o_wdata       (w_dr_wdata),
    .i_waitrequest (bus.sdram_waitrequest),
    .i_rdata       (16'h0000)
  );

  assign bus.sd_chipselect      = w_sd_cs;
  assign bus.sd_read            = w_sd_rd;
  assign bus.sd_write           = w_sd_wr;
  assign bus.sd_address         = w_sd_addr;
  assign bus.sd_byteenable      = 4'hF;
  assign bus.sd_writedata       = w_sd_wdata;

  assign bus.sdram_address      = w_dr_addr;
  assign bus.sdram_byteenable_n = 2'b00;
  assign bus.sdram_chipselect   = w_dr_cs;
  assign bus.sdram_write_n      = ~w_dr_wr;
  assign bus.sdram_read_n       = 1'b1;
  assign bus.sdram_writedata    = w_dr_wdata;

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign error_code   = r_err_code;
  assign sectors_done = r_sectors_done;

endmodule
`default_nettype wire

// File: tb/tb_sd_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_sdram_loader
// Description : Self-checking bench for sd_sdram_loader with behavioural SD
//               card and SDRAM slave models and a sector-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sdram_loader;

  localparam int          AW = 25;
  localparam logic [23:0] PL = 24'd16;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          start        = 1'b0;
  logic [31:0]   sector_start = '0;
  logic [15:0]   sector_count = '0;
  logic [AW-1:0] sdram_base   = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    error_code;
  logic [15:0]   sectors_done;

  sd_sdram_loader_if #(.SDRAM_AW(AW)) bus ();

  sd_sdram_loader #(
    .SDRAM_AW        (AW),
    .POLL_LIMIT      (PL),
    .BYTE_ADDRESSING (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sector_start (sector_start),
    .sector_count (sector_count),
    .sdram_base   (sdram_base),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .error_code   (error_code),
    .sectors_done (sectors_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Slave behaviour knobs, set by the stimulus process
  logic        tb_present      = 1'b1;
  logic        tb_busy_forever = 1'b0;
  logic        tb_cmd_err      = 1'b0;
  int          tb_busy_count   = 0;
  logic [31:0] tb_salt         = '0;
  logic        sd_stall_en     = 1'b0;
  logic        dr_stall_en     = 1'b0;
  logic        dr_hold         = 1'b0;

  // Slave model state, owned by the monitors
  int            sd_busy_left = 0;
  logic [31:0]   sd_last_arg  = '0;
  int            asr_reads    = 0;
  int            buf_reads    = 0;
  int            done_cnt     = 0;
  int            err_cnt      = 0;
  logic          sd_rnd       = 1'b0;
  logic          dr_rnd       = 1'b0;
  logic [39:0]   sd_wq[$];
  logic [AW+15:0] dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // SD buffer content for a given command argument
  function automatic logic [31:0] buf_word(input logic [31:0] arg, input int k);
    return 32'hA5A50000 + 32'(k) + arg * tb_salt;
  endfunction

  // Reference sector data, from sector number
  function automatic logic [31:0] ref_word(input logic [31:0] sector, input int k);
    logic [31:0] byte_addr;
    byte_addr = sector << 9;
    return 32'hA5A50000 + 32'(k) + byte_addr * tb_salt;
  endfunction

  // Random waitrequest generation
  always @(negedge clk) begin
    sd_rnd <= sd_stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    dr_rnd <= dr_stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  assign bus.sd_waitrequest    = sd_rnd;
  assign bus.sdram_waitrequest = dr_hold | dr_rnd;

  // SD read data, valid combinationally for the completing edge
  always_comb begin
    bus.sd_readdata = 32'h0;
    if (bus.sd_address < 8'd128)
      bus.sd_readdata = buf_word(sd_last_arg, int'(bus.sd_address));
    else if (bus.sd_address == 8'd141)
      bus.sd_readdata = {27'd0, tb_cmd_err, 1'b0, (tb_busy_forever || sd_busy_left > 0),
                         tb_present, 1'b0};
  end

  // Transaction monitor for both slaves
  always @(posedge clk) begin
    if (bus.sd_chipselect && !bus.sd_waitrequest && bus.sd_write) begin
      sd_wq.push_back({bus.sd_address, bus.sd_writedata});
      if (bus.sd_address == 8'd139) sd_last_arg <= bus.sd_writedata;
      if (bus.sd_address == 8'd140) sd_busy_left <= tb_busy_count;
    end
    if (bus.sd_chipselect && !bus.sd_waitrequest && bus.sd_read) begin
      if (bus.sd_address == 8'd141) begin
        asr_reads <= asr_reads + 1;
        if (sd_busy_left > 0) sd_busy_left <= sd_busy_left - 1;
      end else if (bus.sd_address < 8'd128) begin
        buf_reads <= buf_reads + 1;
      end
    end
    if (bus.sdram_chipselect && !bus.sdram_write_n && !bus.sdram_waitrequest)
      dq.push_back({bus.sdram_address, bus.sdram_writedata});
  end

  // Pulse counters for done/error
  always @(negedge clk) begin
    if (done)  done_cnt <= done_cnt + 1;
    if (error) err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_end(input int budget);
    int cyc;
    cyc = 0;
    while (!(done || error) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("op_end_seen", 64'(done || error), 64'd1);
    @(negedge clk);
    check("busy_low_after_end", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] sec, input logic [15:0] cnt,
                        input logic [AW-1:0] base, input int budget);
    @(negedge clk);
    sector_start = sec;
    sector_count = cnt;
    sdram_base   = base;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_end(budget);
  endtask

  task automatic check_data(input string tag, input logic [31:0] sec, input int cnt,
                            input logic [AW-1:0] base, input int w0, input int d0);
    int             bad;
    int             idx;
    logic [31:0]    arg;
    logic [31:0]    wrd;
    logic [AW-1:0]  a;
    logic [AW+15:0] e;
    check({tag, "_sd_wr_cnt"}, 64'(sd_wq.size() - w0), 64'(2 * cnt));
    bad = 0;
    for (int s = 0; s < cnt; s++) begin
      arg = (sec + 32'(s)) << 9;
      if (sd_wq.size() >= w0 + 2 * s + 2) begin
        if (sd_wq[w0 + 2 * s] !== {8'd139, arg}) bad++;
        if (sd_wq[w0 + 2 * s + 1] !== {8'd140, 32'd17}) bad++;
      end else begin
        bad++;
      end
    end
    check({tag, "_sd_wr_bad"}, 64'(bad), 64'd0);
    check({tag, "_sdram_wr_cnt"}, 64'(dq.size() - d0), 64'(256 * cnt));
    bad = 0;
    for (int s = 0; s < cnt; s++) begin
      for (int k = 0; k < 128; k++) begin
        wrd = ref_word(sec + 32'(s), k);
        for (int h = 0; h < 2; h++) begin
          idx = d0 + s * 256 + 2 * k + h;
          a   = AW'(32'(base) + 32'(s * 256 + 2 * k + h));
          e   = {a, (h == 1) ? wrd[31:16] : wrd[15:0]};
          if (idx >= dq.size() || dq[idx] !== e) bad++;
        end
      end
    end
    check({tag, "_sdram_wr_bad"}, 64'(bad), 64'd0);
    check({tag, "_sectors_done"}, 64'(sectors_done), 64'(cnt));
    check({tag, "_error_code"}, 64'(error_code), 64'd0);
  endtask

  int a0, b0, w0, d0, e0, n0;

  task automatic snap();
    a0 = asr_reads; b0 = buf_reads; w0 = sd_wq.size(); d0 = dq.size();
    e0 = err_cnt;   n0 = done_cnt;
  endtask

  initial begin
    logic [31:0]   rsec;
    logic [AW-1:0] rbase;
    int            rcnt;
    int            cyc;
    logic          found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_error_code", 64'(error_code), 64'd0);
    check("rst_sectors_done", 64'(sectors_done), 64'd0);
    check("rst_sdram_write_n", 64'(bus.sdram_write_n), 64'd1);
    check("rst_sd_cs", 64'(bus.sd_chipselect), 64'd0);
    check("rst_sdram_cs", 64'(bus.sdram_chipselect), 64'd0);
    reset = 1'b0;

    // Card absent
    tb_present = 1'b0;
    snap();
    run_op(32'd7, 16'd1, '0, 2000);
    check("nocard_err_pulses", 64'(err_cnt - e0), 64'd1);
    check("nocard_done_pulses", 64'(done_cnt - n0), 64'd0);
    check("nocard_code", 64'(error_code), 64'd1);
    check("nocard_asr_reads", 64'(asr_reads - a0), 64'd1);
    check("nocard_sd_writes", 64'(sd_wq.size() - w0), 64'd0);
    check("nocard_sdram_writes", 64'(dq.size() - d0), 64'd0);
    tb_present = 1'b1;

    // Single sector, no stalls
    tb_busy_count = 2;
    tb_salt       = '0;
    snap();
    run_op(32'd5, 16'd1, AW'(32'h100), 20000);
    check_data("one", 32'd5, 1, AW'(32'h100), w0, d0);
    check("one_arg", 64'((sd_wq.size() > w0) ? sd_wq[w0] : 40'h0), 64'({8'd139, 32'h0000_0A00}));
    check("one_first_lo", 64'((dq.size() > d0) ? dq[d0] : '0), 64'({25'h100, 16'h0000}));
    check("one_first_hi", 64'((dq.size() > d0 + 1) ? dq[d0 + 1] : '0), 64'({25'h101, 16'hA5A5}));
    check("one_done_pulses", 64'(done_cnt - n0), 64'd1);
    check("one_err_pulses", 64'(err_cnt - e0), 64'd0);

    // Three sectors with stalls on both slaves
    sd_stall_en = 1'b1;
    dr_stall_en = 1'b1;
    snap();
    run_op(32'd5, 16'd3, AW'(32'h100), 30000);
    check_data("stall3", 32'd5, 3, AW'(32'h100), w0, d0);
    check("stall3_done_pulses", 64'(done_cnt - n0), 64'd1);

    // Randomized runs, first one wrapping the SDRAM address space
    for (int it = 0; it < 3; it++) begin
      rsec          = $urandom;
      rcnt          = $urandom_range(1, 2);
      rbase         = (it == 0) ? AW'(32'h1FF_FF00) : AW'($urandom);
      tb_salt       = $urandom;
      tb_busy_count = $urandom_range(0, 3);
      snap();
      run_op(rsec, 16'(rcnt), rbase, 12000 * rcnt);
      check_data("rand", rsec, rcnt, rbase, w0, d0);
    end
    tb_salt = '0;

    // Poll timeout
    tb_busy_forever = 1'b1;
    snap();
    run_op(32'd9, 16'd1, '0, 3000);
    check("tmo_code", 64'(error_code), 64'd2);
    check("tmo_asr_reads", 64'(asr_reads - a0), 64'(1 + int'(PL)));
    check("tmo_buf_reads", 64'(buf_reads - b0), 64'd0);
    check("tmo_sdram_writes", 64'(dq.size() - d0), 64'd0);
    check("tmo_err_pulses", 64'(err_cnt - e0), 64'd1);
    tb_busy_forever = 1'b0;

    // SD command error
    tb_cmd_err    = 1'b1;
    tb_busy_count = 1;
    snap();
    run_op(32'd9, 16'd1, '0, 3000);
    check("cmderr_code", 64'(error_code), 64'd3);
    check("cmderr_buf_reads", 64'(buf_reads - b0), 64'd0);
    tb_cmd_err = 1'b0;

    // Zero-count request
    snap();
    @(negedge clk);
    sector_count = 16'd0;
    sector_start = 32'd1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done_next", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'd0);
    @(negedge clk);
    check("zero_done_pulses", 64'(done_cnt - n0), 64'd1);
    check("zero_bus_traffic", 64'((asr_reads - a0) + (buf_reads - b0) + (sd_wq.size() - w0)
                                  + (dq.size() - d0)), 64'd0);

    // Start while busy is ignored
    snap();
    @(negedge clk);
    sector_start = 32'd11;
    sector_count = 16'd1;
    sdram_base   = AW'(32'h400);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    sector_start = 32'd99;
    sector_count = 16'd2;
    sdram_base   = AW'(32'h800);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(12000);
    check_data("ignore", 32'd11, 1, AW'(32'h400), w0, d0);
    repeat (20) @(negedge clk);
    check("ignore_still_idle", 64'(busy), 64'd0);
    check("ignore_done_pulses", 64'(done_cnt - n0), 64'd1);

    // Reset during a stalled WHI write
    snap();
    @(negedge clk);
    sector_start = 32'd3;
    sector_count = 16'd1;
    sdram_base   = AW'(32'h200);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < 12000) begin
      if (bus.sdram_chipselect && !bus.sdram_write_n && bus.sdram_address[0]) begin
        found   = 1'b1;
        dr_hold = 1'b1;
        reset   = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rst_whi_seen", 64'(found), 64'd1);
    @(negedge clk);
    check("rst_mid_write_n", 64'(bus.sdram_write_n), 64'd1);
    check("rst_mid_sdram_cs", 64'(bus.sdram_chipselect), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    reset   = 1'b0;
    dr_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_pulse", 64'((done_cnt - n0) + (err_cnt - e0)), 64'd0);
    check("rst_mid_idle", 64'(busy), 64'd0);
    snap();
    run_op(32'd3, 16'd1, AW'(32'h200), 12000);
    check_data("after_rst", 32'd3, 1, AW'(32'h200), w0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
